cam_scan_ctrl: RTL and testbench
================================

Name: cam_scan_ctrl

Overview:
- Search engine for the CAM entry store, sitting directly on the read-only port of dual_port_ram.
- Accepts a key/mask search request and streams addresses into the RAM read port, one per cycle.
- Compares each returned word against the masked key and reports the first matching index, or a miss.
- The write port stays owned by the table-update logic; this block never writes.

Parameters:
- DPW, 10, RAM address width; table holds 2**DPW entries.
- DW, 32, entry/key width.

Ports:
- clk  in  1  single clock; also drives the RAM read-port clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  search request valid.
- req_ready  out  1  high only in IDLE.
- req_key  in  DW  search key.
- req_mask  in  DW  1 = bit participates in compare.
- req_start  in  DPW  first entry index to scan.
- cfg_depth  in  DPW+1  number of populated entries; values above 2**DPW are clamped to 2**DPW.
- ram_addr  out  DPW  to RAM read address.
- ram_rdata  in  DW  from RAM read data; registered, 1-cycle read latency.
- rsp_valid  out  1  result valid; held until rsp_ready.
- rsp_ready  in  1  result accepted.
- rsp_hit  out  1  1 = match found.
- rsp_index  out  DPW  matching index; 0 on miss.
- rsp_data  out  DW  full stored word of the match; 0 on miss.

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, ram_addr=0, rsp_valid=0, rsp_hit=0, rsp_index=0, rsp_data=0, pipeline flags cleared.
- Reset during SCAN or RESP aborts the search with no response.
- States: IDLE, SCAN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch key&mask, mask, and clamped depth D; set ram_addr<=req_start.
  - If req_start>=D, go to RESP with a miss on the next edge. Otherwise go to SCAN.
- SCAN, issue stage: issue_valid=1 while the issue index is below D. ram_addr increments each cycle up to D-1, then holds. Never wraps.
- SCAN, tracking stage: at each edge, pend_valid<=issue_valid and pend_addr<=ram_addr. pend_addr identifies the word present on ram_rdata.
- SCAN, compare: match = pend_valid && (((ram_rdata ^ key) & mask) == 0).
  - On match: go to RESP with rsp_hit=1, rsp_index=pend_addr, rsp_data=ram_rdata. Discard any further issued reads.
  - On miss with pend_addr==D-1: go to RESP with rsp_hit=0.
- Latency, counted in edges after the accept edge A:
  - Hit at entry k: rsp_valid rises at edge A+(k-req_start)+2.
  - Full miss: rsp_valid rises at edge A+(D-req_start)+1.
  - req_start>=D: rsp_valid rises at edge A+1.
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&&rsp_ready, go to IDLE. req_ready returns the next cycle; no request is accepted in the same cycle.
- mask=0 matches any word, so the first scanned entry hits.
- Concurrent port-B writes are not blocked. Each compare uses the word read. A write to the address being read in the same cycle returns the old data.
- Throughput: one entry per cycle. Minimum request-to-request spacing is 3 cycles.

Decomposition:
- cam_pkg: state encodings (IDLE/SCAN/RESP), default CAM_DPW=10 and CAM_DW=32, and the depth-clamp constant.
- One natural sub-module: cam_masked_cmp, a combinational masked equality (key, mask, word -> match). It is reused later by a parallel-bank variant.

Test Plan:
- Entries 0..7 = 0x100+i, D=8, key=0x105, mask=0xFFFFFFFF, start=0, rsp_ready=1 -> rsp_hit=1, rsp_index=5, rsp_data=0x105, rsp_valid at edge A+7.
- Same table, key=0x999 -> rsp_hit=0, rsp_index=0, rsp_data=0, rsp_valid at edge A+9, ram_addr holds at 7.
- Entries 2 and 6 = 0xAB00_0000, key=0xAB12_3456, mask=0xFF00_0000. start=0 -> index 2. Re-issue with start=3 -> index 6.
- start=8, D=8 -> miss at edge A+1. D=0 -> miss at edge A+1. cfg_depth=2000 with DPW=10 -> scan ends at index 1023.
- Hit at index 3 with rsp_ready low for 5 cycles -> rsp_* stable, req_ready=0 throughout. Accept on rsp_ready -> req_ready=1 the following cycle.
- Assert rst_n=0 mid-SCAN at entry 4 -> all outputs at reset values immediately. Release reset -> no rsp_valid; a new request completes normally.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM search engine: default widths, state encoding and
// the depth-clamp helper.
package cam_pkg;

    localparam int unsigned CAM_DPW       = 10;
    localparam int unsigned CAM_DW        = 32;
    localparam int unsigned CAM_DEPTH_MAX = 32'd1 << CAM_DPW;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResp
    } cam_state_e;

    // Largest populated-entry count a table of 2**dpw entries can hold.
    function automatic int unsigned cam_depth_max(input int unsigned dpw);
        return 32'd1 << dpw;
    endfunction

endpackage

// File: rtl/cam_masked_cmp.sv
// Combinational masked equality: match when every mask-selected bit of word equals key.
module cam_masked_cmp #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] key,
    input  logic [DW-1:0] mask,
    input  logic [DW-1:0] word,
    output logic          match
);

    assign match = ((word ^ key) & mask) == '0;

endmodule

// File: rtl/cam_scan_ctrl.sv
// Sequential CAM search: streams addresses into a 1-cycle-latency RAM read port and
// reports the first entry whose masked contents equal the masked key.
module cam_scan_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned DPW = CAM_DPW,
    parameter int unsigned DW  = CAM_DW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [DW-1:0]  req_key,
    input  logic [DW-1:0]  req_mask,
    input  logic [DPW-1:0] req_start,
    input  logic [DPW:0]   cfg_depth,
    output logic [DPW-1:0] ram_addr,
    input  logic [DW-1:0]  ram_rdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_hit,
    output logic [DPW-1:0] rsp_index,
    output logic [DW-1:0]  rsp_data
);

    localparam logic [DPW:0] DepthMax = (DPW+1)'(cam_depth_max(DPW));

    cam_state_e     state_q, state_d;
    logic [DW-1:0]  key_q, key_d;
    logic [DW-1:0]  mask_q, mask_d;
    logic [DPW:0]   depth_q, depth_d;
    logic [DPW-1:0] addr_q, addr_d;
    logic           issue_valid_q, issue_valid_d;
    logic           pend_valid_q, pend_valid_d;
    logic [DPW-1:0] pend_addr_q, pend_addr_d;
    logic           rsp_hit_q, rsp_hit_d;
    logic [DPW-1:0] rsp_index_q, rsp_index_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;

    logic [DPW:0]   req_depth;
    logic [DPW:0]   depth_last;
    logic           last_issue;
    logic           last_pend;
    logic           cmp_match;
    logic           match;

    assign req_depth  = (cfg_depth > DepthMax) ? DepthMax : cfg_depth;
    assign depth_last = depth_q - (DPW+1)'(1);
    assign last_issue = {1'b0, addr_q} == depth_last;
    assign last_pend  = {1'b0, pend_addr_q} == depth_last;

    cam_masked_cmp #(
        .DW (DW)
    ) u_cmp (
        .key   (key_q),
        .mask  (mask_q),
        .word  (ram_rdata),
        .match (cmp_match)
    );

    assign match = pend_valid_q && cmp_match;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        mask_d        = mask_q;
        depth_d       = depth_q;
        addr_d        = addr_q;
        issue_valid_d = issue_valid_q;
        pend_valid_d  = issue_valid_q;
        pend_addr_d   = addr_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_index_d   = rsp_index_q;
        rsp_data_d    = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    key_d         = req_key & req_mask;
                    mask_d        = req_mask;
                    depth_d       = req_depth;
                    addr_d        = req_start;
                    rsp_hit_d     = 1'b0;
                    rsp_index_d   = '0;
                    rsp_data_d    = '0;
                    // An empty scan range still passes through SCAN for one cycle.
                    issue_valid_d = {1'b0, req_start} < req_depth;
                    state_d       = StScan;
                end
            end
            StScan: begin
                if (issue_valid_q) begin
                    if (last_issue) begin
                        issue_valid_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (match) begin
                    state_d       = StResp;
                    rsp_hit_d     = 1'b1;
                    rsp_index_d   = pend_addr_q;
                    rsp_data_d    = ram_rdata;
                    issue_valid_d = 1'b0;
                    pend_valid_d  = 1'b0;
                end else if ((pend_valid_q && last_pend) || (!pend_valid_q && !issue_valid_q)) begin
                    state_d       = StResp;
                    issue_valid_d = 1'b0;
                    pend_valid_d  = 1'b0;
                end
            end
            StResp: begin
                pend_valid_d = 1'b0;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            key_q         <= '0;
            mask_q        <= '0;
            depth_q       <= '0;
            addr_q        <= '0;
            issue_valid_q <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_index_q   <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            mask_q        <= mask_d;
            depth_q       <= depth_d;
            addr_q        <= addr_d;
            issue_valid_q <= issue_valid_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_index_q   <= rsp_index_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign req_ready = state_q == StIdle;
    assign rsp_valid = state_q == StResp;
    assign ram_addr  = addr_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_index = rsp_index_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cam_scan_ctrl.sv
// Directed bench for cam_scan_ctrl with a behavioural 1-cycle-latency RAM read port.
module tb_cam_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_key;
    logic [31:0] req_mask;
    logic [9:0]  req_start;
    logic [10:0] cfg_depth;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [9:0]  rsp_index;
    logic [31:0] rsp_data;

    logic [31:0] mem [1024];

    int n_checks;
    int n_fail;

    cam_scan_ctrl #(
        .DPW (10),
        .DW  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_mask  (req_mask),
        .req_start (req_start),
        .cfg_depth (cfg_depth),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_index (rsp_index),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    // Drives one request, returns the number of edges after the accept edge at which
    // rsp_valid was first seen high (-1 if it never rose within the budget).
    task automatic send_req(input logic [31:0] key, input logic [31:0] mask,
                            input logic [9:0] start, input logic [10:0] depth,
                            output int edges);
        @(negedge clk);
        req_key   = key;
        req_mask  = mask;
        req_start = start;
        cfg_depth = depth;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_key   = '0;
        req_mask  = '0;
        req_start = '0;
        cfg_depth = 11'd8;
        rsp_ready = 1'b1;
        #12;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b ram_addr=%0d, required 1 0 0",
                     req_ready, rsp_valid, ram_addr);
        end
        n_checks++;
        if (rsp_hit !== 1'b0 || rsp_index !== 10'd0 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: hit=%b index=%0d data=%h, required 0 0 0",
                     rsp_hit, rsp_index, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exact_hit();
        int e;
        send_req(32'h105, 32'hFFFF_FFFF, 10'd0, 11'd8, e);
        n_checks++;
        if (e !== 7) begin
            n_fail++;
            $display("FAIL exact_hit_latency: edges=%0d, required 7", e);
        end
        n_checks++;
        if (rsp_hit !== 1'b1 || rsp_index !== 10'd5 || rsp_data !== 32'h105) begin
            n_fail++;
            $display("FAIL exact_hit_result: hit=%b index=%0d data=%h, required 1 5 00000105",
                     rsp_hit, rsp_index, rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_full_miss();
        int e;
        send_req(32'h999, 32'hFFFF_FFFF, 10'd0, 11'd8, e);
        n_checks++;
        if (e !== 9) begin
            n_fail++;
            $display("FAIL full_miss_latency: edges=%0d, required 9", e);
        end
        n_checks++;
        if (rsp_hit !== 1'b0 || rsp_index !== 10'd0 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL full_miss_result: hit=%b index=%0d data=%h, required 0 0 0",
                     rsp_hit, rsp_index, rsp_data);
        end
        n_checks++;
        if (ram_addr !== 10'd7) begin
            n_fail++;
            $display("FAIL full_miss_addr_hold: ram_addr=%0d, required 7", ram_addr);
        end
        finish_rsp();
    endtask

    task automatic test_masked();
        int e;
        mem[2] = 32'hAB00_0000;
        mem[6] = 32'hAB00_0000;
        send_req(32'hAB12_3456, 32'hFF00_0000, 10'd0, 11'd8, e);
        n_checks++;
        if (e !== 4 || rsp_hit !== 1'b1 || rsp_index !== 10'd2 || rsp_data !== 32'hAB00_0000) begin
            n_fail++;
            $display("FAIL masked_first: edges=%0d hit=%b index=%0d data=%h, required 4 1 2 ab000000",
                     e, rsp_hit, rsp_index, rsp_data);
        end
        finish_rsp();
        send_req(32'hAB12_3456, 32'hFF00_0000, 10'd3, 11'd8, e);
        n_checks++;
        if (e !== 5 || rsp_hit !== 1'b1 || rsp_index !== 10'd6 || rsp_data !== 32'hAB00_0000) begin
            n_fail++;
            $display("FAIL masked_restart: edges=%0d hit=%b index=%0d data=%h, required 5 1 6 ab000000",
                     e, rsp_hit, rsp_index, rsp_data);
        end
        finish_rsp();
        mem[2] = 32'h102;
        mem[6] = 32'h106;
        // Zero mask matches whatever entry is scanned first.
        send_req(32'h1234_5678, 32'h0, 10'd4, 11'd8, e);
        n_checks++;
        if (e !== 2 || rsp_hit !== 1'b1 || rsp_index !== 10'd4 || rsp_data !== 32'h104) begin
            n_fail++;
            $display("FAIL zero_mask: edges=%0d hit=%b index=%0d data=%h, required 2 1 4 00000104",
                     e, rsp_hit, rsp_index, rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_boundaries();
        int e;
        send_req(32'h100, 32'hFFFF_FFFF, 10'd8, 11'd8, e);
        n_checks++;
        if (e !== 1 || rsp_hit !== 1'b0 || rsp_index !== 10'd0 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL start_past_depth: edges=%0d hit=%b index=%0d, required 1 0 0",
                     e, rsp_hit, rsp_index);
        end
        finish_rsp();
        send_req(32'h100, 32'hFFFF_FFFF, 10'd0, 11'd0, e);
        n_checks++;
        if (e !== 1 || rsp_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_depth: edges=%0d hit=%b, required 1 0", e, rsp_hit);
        end
        finish_rsp();
        send_req(32'h999, 32'hFFFF_FFFF, 10'd1020, 11'd2000, e);
        n_checks++;
        if (e !== 5 || rsp_hit !== 1'b0 || ram_addr !== 10'd1023) begin
            n_fail++;
            $display("FAIL clamp_miss: edges=%0d hit=%b ram_addr=%0d, required 5 0 1023",
                     e, rsp_hit, ram_addr);
        end
        finish_rsp();
        mem[1023] = 32'h0C0F_FEE0;
        send_req(32'h0C0F_FEE0, 32'hFFFF_FFFF, 10'd1020, 11'd2000, e);
        n_checks++;
        if (e !== 5 || rsp_hit !== 1'b1 || rsp_index !== 10'd1023 || rsp_data !== 32'h0C0F_FEE0) begin
            n_fail++;
            $display("FAIL clamp_last_hit: edges=%0d hit=%b index=%0d data=%h, required 5 1 1023 0c0ffee0",
                     e, rsp_hit, rsp_index, rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int e;
        int bad;
        rsp_ready = 1'b0;
        send_req(32'h103, 32'hFFFF_FFFF, 10'd0, 11'd8, e);
        n_checks++;
        if (e !== 5) begin
            n_fail++;
            $display("FAIL hold_latency: edges=%0d, required 5", e);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_index !== 10'd3 ||
                rsp_data !== 32'h103 || req_ready !== 1'b0) begin
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0 (last index=%0d ready=%b)",
                     bad, rsp_index, req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_ready: req_ready=%b rsp_valid=%b, required 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int e;
        int seen;
        @(negedge clk);
        req_key   = 32'h999;
        req_mask  = 32'hFFFF_FFFF;
        req_start = 10'd0;
        cfg_depth = 11'd8;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (ram_addr !== 10'd4 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_scan_addr: ram_addr=%0d rsp_valid=%b, required 4 0", ram_addr, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || ram_addr !== 10'd0 || rsp_valid !== 1'b0 ||
            rsp_hit !== 1'b0 || rsp_index !== 10'd0 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_reset: ready=%b addr=%0d valid=%b hit=%b index=%0d data=%h, required 1 0 0 0 0 0",
                     req_ready, ram_addr, rsp_valid, rsp_hit, rsp_index, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_rsp: rsp_valid seen %0d cycles, required 0", seen);
        end
        send_req(32'h102, 32'hFFFF_FFFF, 10'd0, 11'd8, e);
        n_checks++;
        if (e !== 4 || rsp_hit !== 1'b1 || rsp_index !== 10'd2 || rsp_data !== 32'h102) begin
            n_fail++;
            $display("FAIL after_abort: edges=%0d hit=%b index=%0d data=%h, required 4 1 2 00000102",
                     e, rsp_hit, rsp_index, rsp_data);
        end
        finish_rsp();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h5A00_0000 | i;
        end
        for (int i = 0; i < 8; i++) begin
            mem[i] = 32'h100 + i;
        end
        test_reset();
        test_exact_hit();
        test_full_miss();
        test_masked();
        test_boundaries();
        test_backpressure();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
